// File: rtl/vga_timing_gen.sv
// VGA timing + output stage; optional colour bars under VGA_TEST_PATTERN_EN. Latency PIX_LATENCY+1 clocks
// from counters to pins for sync, blank and colour alike; free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_LATENCY = 1,
  parameter int COLOR_W     = 8,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW         = $clog2(H_TOTAL),
  localparam int YW         = $clog2(V_TOTAL)
) (
  input  logic                 VGA_CLK_IN,
  input  logic                 reset,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  input  logic                 test_en,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_req,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 VGA_CLK_OUT
);

  generate
    if (PIX_LATENCY < 0 || PIX_LATENCY > 7) begin : g_bad_latency
      $error("vga_timing_gen: PIX_LATENCY must be in 0..7");
    end
`ifdef VGA_TEST_PATTERN_EN
    if (H_ACTIVE % 8 != 0) begin : g_bad_bar_width
      $error("vga_timing_gen: H_ACTIVE must be divisible by 8 for the colour bars");
    end
`endif
  endgenerate

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
`ifdef VGA_TEST_PATTERN_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } stage_t;

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  always_comb begin
    h_last  = (h_cnt_q == XW'(H_TOTAL - 1));
    v_last  = (v_cnt_q == YW'(V_TOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
    if (reset) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    h_cnt_q <= h_cnt_d;
    v_cnt_q <= v_cnt_d;
  end

  stage_t raw_s;
  stage_t dly_s;

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);
  assign pix_req     = raw_s.de;
  assign VGA_CLK_OUT = VGA_CLK_IN;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // The frame's mode is latched at frame_start; that first pixel already uses the new value.
  logic       tp_mode_q, tp_mode_d;
  logic [2:0] bar_idx;

  always_comb begin
    tp_mode_d = frame_start ? test_en : tp_mode_q;
    if (reset) begin
      tp_mode_d = 1'b0;
    end
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= XW'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    tp_mode_q <= tp_mode_d;
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
`endif

  always_comb begin
    raw_s    = '0;
    raw_s.de = (h_cnt_q < XW'(H_ACTIVE)) && (v_cnt_q < YW'(V_ACTIVE));
    raw_s.hs = (h_cnt_q >= XW'(H_ACTIVE + H_FP)) &&
               (h_cnt_q <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
    raw_s.vs = (v_cnt_q >= YW'(V_ACTIVE + V_FP)) &&
               (v_cnt_q <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));
`ifdef VGA_TEST_PATTERN_EN
    raw_s.tp  = tp_mode_d;
    raw_s.bar = bar_idx;
`endif
  end

  generate
    if (PIX_LATENCY == 0) begin : g_no_delay
      assign dly_s = raw_s;
    end else begin : g_delay
      stage_t pipe_q [PIX_LATENCY];
      stage_t pipe_d [PIX_LATENCY];

      always_comb begin
        pipe_d[0] = reset ? '0 : raw_s;
        for (int i = 1; i < PIX_LATENCY; i++) begin
          pipe_d[i] = reset ? '0 : pipe_q[i-1];
        end
      end

      always_ff @(posedge VGA_CLK_IN) begin
        pipe_q <= pipe_d;
      end

      assign dly_s = pipe_q[PIX_LATENCY-1];
    end
  endgenerate

  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               blank_n_q, blank_n_d, hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    blank_n_d = 1'b0;
    hsync_d   = ~HSYNC_POL;
    vsync_d   = ~VSYNC_POL;
    if (!reset) begin
      blank_n_d = dly_s.de;
      hsync_d   = dly_s.hs ~^ HSYNC_POL;
      vsync_d   = dly_s.vs ~^ VSYNC_POL;
      if (dly_s.de) begin
`ifdef VGA_TEST_PATTERN_EN
        // Bar order white..black maps onto inverted bits of the bar index.
        if (dly_s.tp) begin
          red_d   = {COLOR_W{~dly_s.bar[1]}};
          green_d = {COLOR_W{~dly_s.bar[2]}};
          blue_d  = {COLOR_W{~dly_s.bar[0]}};
        end else begin
          {red_d, green_d, blue_d} = pix_rgb;
        end
`else
        {red_d, green_d, blue_d} = pix_rgb;
`endif
      end
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    red_q     <= red_d;
    green_q   <= green_d;
    blue_q    <= blue_d;
    blank_n_q <= blank_n_d;
    hsync_q   <= hsync_d;
    vsync_q   <= vsync_d;
  end

  assign red     = red_q;
  assign green   = green_q;
  assign blue    = blue_q;
  assign blank_n = blank_n_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small geometry (24-clock lines, 7-line frames),
// with random reset pulses, random pixel data and random test_en toggles.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int PL = 2;
  localparam int CW = 8;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int NCYC = 3000;

  logic            clk = 1'b0;
  logic            reset;
  logic            test_en;
  logic [3*CW-1:0] pix_rgb;
  logic [4:0]      pix_x;
  logic [2:0]      pix_y;
  logic            pix_req, line_start, frame_start, hsync, vsync, blank_n, clk_out;
  logic [CW-1:0]   red, green, blue;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIX_LATENCY(PL), .COLOR_W(CW)
  ) dut (
    .VGA_CLK_IN(clk), .reset(reset), .pix_rgb(pix_rgb), .test_en(test_en),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .VGA_CLK_OUT(clk_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cur_n   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cur_n, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / (HA / 8))
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Index n = the clock period following rising edge n; *_e[n] = input sampled at edge n.
  int          h_hist   [NCYC+1];
  int          v_hist   [NCYC+1];
  bit          mode_hist[NCYC+1];
  bit          rst_e    [NCYC+2];
  bit          te_e     [NCYC+2];
  logic [23:0] rgb_e    [NCYC+2];

  initial begin
    int          last_r, cnt, h, v, m, rst_left;
    bit          de_x, hs_x, vs_x, te, nr;
    logic [23:0] col_x, rgb;

    reset    = 1'b1;
    test_en  = 1'b0;
    pix_rgb  = 24'($urandom);
    rst_e[0] = 1'b1;
    te_e[0]  = 1'b0;
    rgb_e[0] = pix_rgb;
    last_r   = 0;
    rst_left = 0;
    te       = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      cur_n = n;
      if (rst_e[n]) last_r = n;
      cnt = n - last_r;
      h = cnt % HT;
      v = (cnt / HT) % VT;
      h_hist[n] = h;
      v_hist[n] = v;

      check("pix_x", 32'(pix_x), 32'(h));
      check("pix_y", 32'(pix_y), 32'(v));
      check("pix_req", 32'(pix_req), 32'(h < HA && v < VA));
      check("line_start", 32'(line_start), 32'(h == 0));
      check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
      check("clk_out", 32'(clk_out), 32'(clk));

      // The pins now show the request made PL+1 clocks ago, unless a reset cleared it.
      m = n - 1 - PL;
      de_x = 1'b0; hs_x = 1'b0; vs_x = 1'b0; col_x = '0;
      if (!rst_e[n] && m >= last_r) begin
        de_x = (h_hist[m] < HA) && (v_hist[m] < VA);
        hs_x = (h_hist[m] >= HA + HFP) && (h_hist[m] < HA + HFP + HS);
        vs_x = (v_hist[m] >= VA + VFP) && (v_hist[m] < VA + VFP + VS);
        if (de_x) col_x = mode_hist[m] ? bar_rgb(h_hist[m]) : rgb_e[n];
      end
      check("blank_n", 32'(blank_n), 32'(de_x));
      check("hsync", 32'(hsync), 32'(hs_x ? HPOL : !HPOL));
      check("vsync", 32'(vsync), 32'(vs_x ? VPOL : !VPOL));
      check("rgb", 32'({red, green, blue}), 32'(col_x));

      if (n + 1 < 3) begin
        nr = 1'b1;
      end else if (rst_left > 0) begin
        nr = 1'b1;
        rst_left--;
      end else if (n > 600 && $urandom_range(0, 249) == 0) begin
        nr = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        nr = 1'b0;
      end

      // Pixel source: red carries the x requested PL clocks ago, green/blue are noise.
      if (n - PL >= last_r) rgb = {8'(h_hist[n-PL]), 16'($urandom)};
      else                  rgb = 24'($urandom);
      if ($urandom_range(0, 99) == 0) te = !te;

      reset        = nr;
      pix_rgb      = rgb;
      test_en      = te;
      rst_e[n+1]   = nr;
      rgb_e[n+1]   = rgb;
      te_e[n+1]    = te;
`ifdef VGA_TEST_PATTERN_EN
      mode_hist[n] = (h == 0 && v == 0) ? te_e[n+1] : mode_hist[n-1];
`else
      mode_hist[n] = 1'b0;
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
